// File: rtl/pam_mod.sv
// Pulse-amplitude modulator: one buffered sample per frame, scaled by a Q.GAIN_FRAC
// gain and emitted either as a flat-top pulse or held for the whole frame.
module pam_mod #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CNT_W-1:0]         period_cfg,
  input  logic [CNT_W-1:0]         width_cfg,
  input  logic [GAIN_W-1:0]        gain_cfg,
  input  logic                     mode,
  output logic signed [DATA_W-1:0] pam_out,
  output logic                     pulse_o,
  output logic                     frame_o,
  output logic                     underrun
);

  localparam int PW = DATA_W + GAIN_W + 1;
  localparam logic signed [PW-1:0] MAXV =
    PW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                     full_q, full_d;
  logic signed [DATA_W-1:0] buf_q, buf_d;
  logic signed [DATA_W-1:0] act_q, act_d;
  logic [CNT_W-1:0]         per_q, per_d;
  logic [CNT_W-1:0]         wid_q, wid_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic                     mode_q, mode_d;
  logic signed [DATA_W-1:0] pam_q, pam_d;
  logic                     pulse_q, pulse_d;
  logic                     frame_q, frame_d;
  logic                     und_q, und_d;

  logic                     fs;
  logic                     accept;
  logic                     busy;
  logic                     in_pulse;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shf;
  logic signed [DATA_W-1:0] scaled;

  assign fs      = !rst && (cnt_q == '0) && (period_cfg != '0);
  assign s_ready = !rst && (!full_q || fs);
  assign accept  = s_valid && s_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    per_d  = fs ? period_cfg : per_q;
    wid_d  = fs ? width_cfg  : wid_q;
    gain_d = fs ? gain_cfg   : gain_q;
    mode_d = fs ? mode       : mode_q;
    act_d  = (fs && full_q) ? buf_q : act_q;
    buf_d  = accept ? s_data : buf_q;
    full_d = fs ? accept : (full_q || accept);
    und_d  = und_q || (fs && !full_q);

    cnt_d = '0;
    if (fs)
      cnt_d = (period_cfg == CNT_W'(1)) ? '0 : CNT_W'(1);
    else if (cnt_q != '0)
      cnt_d = (cnt_inc == per_q) ? '0 : cnt_inc;

    // Outputs for this cycle's count use the values the frame will run with,
    // so the frame-start cycle already sees the freshly loaded sample and gain.
    prod = $signed(act_d) * $signed({1'b0, gain_d});
    shf  = prod >>> GAIN_FRAC;
    if (shf > MAXV)
      scaled = MAXV[DATA_W-1:0];
    else if (shf < MINV)
      scaled = MINV[DATA_W-1:0];
    else
      scaled = shf[DATA_W-1:0];

    busy     = fs || (cnt_q != '0);
    in_pulse = cnt_q < wid_d;
    pulse_d  = busy && in_pulse;
    frame_d  = fs;
    pam_d    = (busy && (mode_d || in_pulse)) ? scaled : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      full_q  <= 1'b0;
      buf_q   <= '0;
      act_q   <= '0;
      per_q   <= '0;
      wid_q   <= '0;
      gain_q  <= '0;
      mode_q  <= 1'b0;
      pam_q   <= '0;
      pulse_q <= 1'b0;
      frame_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      act_q   <= act_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      gain_q  <= gain_d;
      mode_q  <= mode_d;
      pam_q   <= pam_d;
      pulse_q <= pulse_d;
      frame_q <= frame_d;
      und_q   <= und_d;
    end
  end

  assign pam_out  = pam_q;
  assign pulse_o  = pulse_q;
  assign frame_o  = frame_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_pam_mod.sv
// Bench for pam_mod: table of frame configurations plus directed
// underrun, mid-frame width change, reset and idle sequences.
module tb_pam_mod;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [7:0]         period_cfg;
  logic [7:0]         width_cfg;
  logic [7:0]         gain_cfg;
  logic               mode;
  logic signed [15:0] pam_out;
  logic               pulse_o;
  logic               frame_o;
  logic               underrun;

  pam_mod dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .period_cfg (period_cfg),
    .width_cfg  (width_cfg),
    .gain_cfg   (gain_cfg),
    .mode       (mode),
    .pam_out    (pam_out),
    .pulse_o    (pulse_o),
    .frame_o    (frame_o),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               fr;
    logic               pu;
    logic               un;
    logic signed [15:0] pam;
  } exp_t;

  typedef struct {
    int                 per;
    int                 wid;
    int                 gain;
    bit                 md;
    logic signed [15:0] din;
    logic signed [15:0] scaled;
    int                 frames;
  } row_t;

  int   errs   = 0;
  int   checks = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, want);
    end
  endtask

  // Called right after a falling edge with inputs for this cycle applied.
  task automatic step(input exp_t e, input bit rc = 1'b0,
                      input bit re = 1'b0);
    exp_t g;
    #1;
    if (rc) chk("s_ready", {31'd0, s_ready}, {31'd0, re});
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sb.pop_front();
    chk("frame_o", {31'd0, frame_o}, {31'd0, g.fr});
    chk("pulse_o", {31'd0, pulse_o}, {31'd0, g.pu});
    chk("underrun", {31'd0, underrun}, {31'd0, g.un});
    chk("pam_out", 32'(pam_out), 32'(g.pam));
  endtask

  function automatic exp_t ex(input int c, input int w, input bit md,
                              input logic signed [15:0] v, input bit un);
    exp_t e;
    e.fr  = (c == 0);
    e.pu  = (c < w);
    e.pam = (md || c < w) ? v : 16'sd0;
    e.un  = un;
    return e;
  endfunction

  function automatic exp_t idle(input bit un);
    exp_t e;
    e.fr  = 1'b0;
    e.pu  = 1'b0;
    e.pam = 16'sd0;
    e.un  = un;
    return e;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = 16'sd0;
    period_cfg = 8'd0;
    width_cfg  = 8'd0;
    gain_cfg   = 8'd0;
    mode       = 1'b0;
    step(idle(1'b0), 1'b1, 1'b0);
    step(idle(1'b0), 1'b1, 1'b0);
    rst = 1'b0;
  endtask

  // Load the one-entry buffer while the modulator is idle.
  task automatic preload(input logic signed [15:0] d);
    period_cfg = 8'd0;
    s_valid    = 1'b1;
    s_data     = d;
    step(idle(1'b0), 1'b1, 1'b1);
  endtask

  task automatic run_frames(input int p, input int w, input int g,
                            input bit md, input logic signed [15:0] v,
                            input int n, input int un_from);
    period_cfg = 8'(p);
    width_cfg  = 8'(w);
    gain_cfg   = 8'(g);
    mode       = md;
    for (int f = 0; f < n; f++)
      for (int c = 0; c < p; c++)
        step(ex(c, w, md, v, f >= un_from));
  endtask

  row_t rows[8];

  initial begin
    rows[0] = '{8, 3, 128, 1'b0, 16'sd1000, 16'sd1000, 2};
    rows[1] = '{8, 3, 128, 1'b1, 16'sd1000, 16'sd1000, 2};
    rows[2] = '{4, 2, 255, 1'b0, 16'sd32767, 16'sd32767, 2};
    rows[3] = '{4, 2, 255, 1'b1, -16'sd32768, -16'sd32768, 2};
    rows[4] = '{4, 4, 64, 1'b0, -16'sd1000, -16'sd500, 2};
    rows[5] = '{3, 0, 128, 1'b0, 16'sd500, 16'sd500, 2};
    rows[6] = '{1, 1, 128, 1'b0, 16'sd7, 16'sd7, 4};
    rows[7] = '{5, 9, 128, 1'b1, -16'sd3, -16'sd3, 2};

    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      preload(rows[i].din);
      run_frames(rows[i].per, rows[i].wid, rows[i].gain, rows[i].md,
                 rows[i].scaled, rows[i].frames, 1000);
    end

    // Mid-frame width change applies from the next frame only.
    do_reset();
    preload(16'sd100);
    period_cfg = 8'd8;
    width_cfg  = 8'd3;
    gain_cfg   = 8'd128;
    mode       = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 8; c++) begin
        if (f == 0 && c == 4) width_cfg = 8'd6;
        step(ex(c, (f == 0) ? 3 : 6, 1'b0, 16'sd100, 1'b0));
      end

    // Underrun: only the preloaded sample, active value repeats.
    do_reset();
    preload(16'sd1234);
    s_valid = 1'b0;
    run_frames(4, 2, 128, 1'b0, 16'sd1234, 3, 1);
    step(ex(0, 2, 1'b0, 16'sd1234, 1'b1));
    step(ex(1, 2, 1'b0, 16'sd1234, 1'b1));

    // Reset mid-frame clears everything, including underrun.
    rst = 1'b1;
    step(idle(1'b0), 1'b1, 1'b0);
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'sd55;
    run_frames(4, 2, 128, 1'b0, 16'sd0, 1, 0);
    run_frames(4, 2, 128, 1'b0, 16'sd55, 1, 0);

    // Idle period: outputs drop to zero, buffer full so no acceptance.
    period_cfg = 8'd0;
    step(idle(1'b1), 1'b1, 1'b0);
    step(idle(1'b1), 1'b1, 1'b0);

    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pam_mod.md
PAM_MOD -- requirements
Module: pam_mod

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 16, signed sample and output width.
- CNT_W, 8, width of the period and width configuration.
- GAIN_W, 8, unsigned gain width.
- GAIN_FRAC, 7, gain fractional bits; gain 128 equals unity.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock, rising edge only.
- rst, in, 1, synchronous active-high reset.
- s_data, in, DATA_W, signed message sample.
- s_valid, in, 1, sample offered.
- s_ready, out, 1, sample accepted when s_valid and s_ready are both high.
- period_cfg, in, CNT_W, frame length in cycles; 0 means idle.
- width_cfg, in, CNT_W, pulse-high cycles per frame.
- gain_cfg, in, GAIN_W, amplitude scale.
- mode, in, 1, 0 = return-to-zero flat-top, 1 = hold for the full frame.
- pam_out, out, DATA_W, signed registered PAM output.
- pulse_o, out, 1, registered pulse-active flag.
- frame_o, out, 1, registered one-cycle frame-start strobe.
- underrun, out, 1, sticky flag: a frame started with no sample buffered.

Function
REQ-003 Frame counter cnt SHALL count 0..P-1 and then wrap to 0, where P is the period latched at frame start.
REQ-004 A frame-start event SHALL occur in every cycle with cnt==0 and period_cfg!=0, outside reset.
REQ-005 At a frame-start event, period_cfg, width_cfg, gain_cfg and mode SHALL be latched; mid-frame changes to these inputs SHALL have no effect until the next frame.
REQ-006 When period_cfg==0 at cnt==0, the block SHALL hold cnt at 0, consume no sample, and drive pulse_o=0, frame_o=0 and pam_out=0 from the next cycle on.
REQ-007 Input SHALL pass through a one-entry buffer; s_ready SHALL equal (!full || frame-start event), combinationally.
REQ-008 At a frame start with the buffer full, the buffered sample SHALL move to the active register; a sample accepted in the same cycle SHALL refill the buffer.
REQ-009 At a frame start with the buffer empty, the active register SHALL keep its previous value and underrun SHALL set; a sample accepted in that cycle SHALL be stored and not used.
REQ-010 Scaled value SHALL be (active × gain) arithmetic-shifted right by GAIN_FRAC, full precision, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-011 Let c be the cnt value of a cycle and W the latched width. The outputs SHALL be registered and reflect c one cycle later:
- pulse_o = (c < W).
- frame_o = (c == 0).
- mode 0: pam_out = scaled when c < W, else 0.
- mode 1: pam_out = scaled for all c.
REQ-012 If W==0, pulse_o SHALL stay 0 and pam_out SHALL be 0 in mode 0.
REQ-013 If W>=P, pulse_o SHALL stay 1 for the whole frame.
REQ-014 With P==1, every cycle SHALL be a frame start.
REQ-015 The scaled value used by a frame SHALL come from that frame's active sample and latched gain (latency: the first output of a frame appears one cycle after its frame-start cycle).

Reset
REQ-016 While rst is high at a rising edge, the block SHALL set:
- cnt=0, buffer empty, active register=0, latched configuration=0.
- pam_out=0, pulse_o=0, frame_o=0, underrun=0.
REQ-017 Reset mid-frame SHALL discard the buffered and active samples; the first frame start SHALL occur in the first cycle after rst falls with period_cfg!=0.
REQ-018 s_ready SHALL be 0 while rst is high.
REQ-019 underrun SHALL clear only on reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Period 8, width 3, gain 128, mode 0, s_data=1000 always valid -> per frame: pulse_o 1,1,1,0,0,0,0,0; pam_out 1000 ×3 then 0 ×5; frame_o on the first cycle.
- Same configuration with mode 1 -> pam_out=1000 for all 8 cycles; pulse_o unchanged.
- Gain 255 with s_data=32767 -> pam_out=32767 (saturated); s_data=-32768 -> -32768; gain 64 with s_data=-1000 -> -500.
- s_valid held low after the first sample -> underrun=1 at the second frame start; pam_out repeats the last sample.
- width_cfg changed 3->6 at cnt=4 -> current frame keeps 3 pulse cycles; next frame has 6.
- period_cfg=0 -> outputs 0 and s_ready low once the buffer is full; rst asserted mid-frame -> all outputs 0 the next cycle, underrun cleared.
